vga_text_render: RTL and testbench
==================================

# vga_text_render

Text-mode pixel generator sitting directly downstream of the VGA timing core. Consumes the core's pixel address, active flag and raw syncs; reads an 80x30 character RAM and an 8x16 font ROM, both synchronous, through a fixed 3-stage pipeline. Drives 12-bit RGB plus syncs delayed by the same 3 cycles, so the monitor sees aligned pixels. Also provides attribute blink and an underline cursor.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 30, character rows
- BLINK_BIT, 4, frame-counter bit giving blink phase (16 frames per half-period, ~0.53 s at 60 Hz)

Ports:
- vga_clk  in  1  25 MHz pixel clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- addr  in  19  pixel address from timing core: [18:10] row, [9:0] col
- v_active  in  1  pixel is in visible 640x480 area
- h_sync, v_sync  in  1 each  raw syncs from timing core
- char_addr  out  12  character RAM read address
- char_data  in  16  cell word, valid 1 cycle after char_addr: [7:0] code, [10:8] fg {r,g,b}, [13:11] bg {r,g,b}, [14] reserved, [15] blink
- font_addr  out  12  font ROM address {code, line[3:0]}
- font_data  in  8  glyph line, valid 1 cycle after font_addr; bit 7 = leftmost pixel
- cursor_x  in  7  cursor column 0..79
- cursor_y  in  5  cursor row 0..29
- cursor_en  in  1  cursor visible
- r, g, b  out  4 each  pixel colour
- hs, vs  out  1 each  syncs delayed 3 cycles

## Operation
- Cycle t (stage 0): char_addr = row[8:4]*COLS + col[9:3], computed combinationally as (r<<6)+(r<<4)+c, 12 bits unsigned. Registered alongside: row[3:0], col[2:0], cell position, v_active, h_sync, v_sync.
- Cycle t+1 (stage 1): font_addr = {char_data[7:0], line}, combinational from char_data and the stage-0 line register. Attribute bits and cursor match (cell_y == cursor_y && cell_x == cursor_x) are registered with the remaining pipe.
- Cycle t+2 (stage 2): pixel bit = font_data[7 - col[2:0]].
  - Blink: if attribute blink=1 and blink phase=1, fg is replaced by bg.
  - Cursor: if cursor_en, cursor match, line is 14 or 15 and blink phase=0, the pixel is forced to fg.
  - Colour: selected 3-bit colour; each bit expands to 4'hF or 4'h0.
  - If delayed v_active=0, rgb is 0.
  - Result registered onto r/g/b/hs/vs.
- Frame counter: 5-bit. Increments on a v_sync falling edge (previous sample 1, current 0), detected on the raw input. Wraps 31->0. Blink phase = frame_cnt[BLINK_BIT].
- During blanking, char_addr may reach 2607. The RAM must be 4096 deep or tolerate out-of-range reads; the data is ignored.

## Timing
- Latency: inputs at edge t appear on r/g/b/hs/vs after edge t+3, for every pixel. No stalls, no handshake; one pixel per cycle.
- Reset (synchronous, takes effect at the edge where rst=1): r=g=b=0, hs=0, vs=0, all pipe valid/sync bits=0, frame_cnt=0, v_sync_prev=0. char_addr and font_addr are combinational and follow inputs even in reset.
- Reset mid-frame: for 3 cycles after rst deasserts, outputs show flushed pipe zeros, then resume in step with the timing core. Reset must not produce a spurious frame increment.
- v_sync edge on the same cycle as rst: reset wins.
- Cursor and attribute changes take effect on the next pixel read; no latching per frame.

## Structure
- Package vga_text_pkg holds:
  - COLS, ROWS, PIPE_LAT=3
  - Attribute field positions: CODE_LSB=0, FG_LSB=8, BG_LSB=11, BLINK_POS=15
  - Cursor line range constants 14..15
- Sub-module vga_sync_delay(WIDTH, DEPTH): synchronously reset shift register carrying {v_active, h_sync, v_sync}, reused for PIPE_LAT alignment.

## Test plan
- Reset hold then release, cells all code 0x41 with fg=3'b111, bg=0 → after edge 3, hs/vs match inputs delayed 3 cycles exactly; rgb=0 for every pixel with v_active=0.
- Pixel row=0, col=0, font_data=8'h80 → r=g=b=4'hF at t+3. col=1 → 0. Check char_addr=0 and font_addr={8'h41,4'h0}.
- row=479, col=639 → char_addr=29*80+79=2399; font line=15.
- Blink cell with fg=3'b100, bg=3'b001, glyph pixel 1 → b=4'hF,r=0 while frame_cnt[4]=1; r=4'hF while frame_cnt[4]=0. Verify toggle after 16 v_sync falling edges and wrap at 32.
- cursor_en=1, cursor (5,3), blank glyph, fg=3'b010 → g=4'hF on lines 14–15 of cell (5,3) only when phase=0. No effect with cursor_en=0.
- Assert rst for 1 cycle mid-line → outputs 0 for 4 edges, then resume aligned; frame_cnt=0.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants and helpers for the text-mode pixel pipeline.
package vga_text_pkg;

   localparam int COLS     = 80;
   localparam int ROWS     = 30;
   localparam int PIPE_LAT = 3;

   localparam int CODE_LSB  = 0;
   localparam int FG_LSB    = 8;
   localparam int BG_LSB    = 11;
   localparam int BLINK_POS = 15;

   localparam logic [3:0] CURSOR_LINE_LO = 4'd14;
   localparam logic [3:0] CURSOR_LINE_HI = 4'd15;

   typedef struct packed {
      logic v_active;
      logic h_sync;
      logic v_sync;
   } sync_t;

   function automatic logic [3:0] expand_bit(input logic bit_v);
      return bit_v ? 4'hF : 4'h0;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Synchronously reset shift register used to keep control bits aligned with the data pipe.
module vga_sync_delay #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_text_render.sv
// Text-mode pixel generator: char RAM -> font ROM -> colour, three cycles from address to RGB.
module vga_text_render
   import vga_text_pkg::*;
#(
   parameter int COLS      = vga_text_pkg::COLS,
   parameter int ROWS      = vga_text_pkg::ROWS,
   parameter int BLINK_BIT = 4
) (
   input  logic        vga_clk,
   input  logic        rst,
   input  logic [18:0] addr,
   input  logic        v_active,
   input  logic        h_sync,
   input  logic        v_sync,
   output logic [11:0] char_addr,
   input  logic [15:0] char_data,
   output logic [11:0] font_addr,
   input  logic [7:0]  font_data,
   input  logic [6:0]  cursor_x,
   input  logic [4:0]  cursor_y,
   input  logic        cursor_en,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        hs,
   output logic        vs
);

   localparam int ROW_W = $clog2(ROWS);

   logic [ROW_W-1:0] cy_s;
   logic [6:0]       cx_s;
   logic [3:0]       line0_q, line1_q;
   logic [2:0]       px0_q, px1_q;
   logic [ROW_W-1:0] cy0_q;
   logic [6:0]       cx0_q;
   logic [2:0]       fg1_q, bg1_q;
   logic             blink1_q, cur1_q;
   sync_t            sync_in_s, sync2_s;
   logic             vs_prev_q;
   logic [4:0]       frame_q, frame_d;
   logic [3:0]       r_q, g_q, b_q, r_d, g_d, b_d;
   logic             hs_q, vs_q;
   logic             phase_s, pix_s, cursor_hit_s, unused_s;
   logic [2:0]       fg_sel_s, colour_s;

   assign cy_s = addr[10 + 4 +: ROW_W];
   assign cx_s = addr[9:3];
   // 80 columns decomposes into 64 + 16, so the multiply collapses to two shifts and an add.
   assign char_addr = (COLS == 80) ? (12'(cy_s) << 6) + (12'(cy_s) << 4) + 12'(cx_s)
                                   : 12'(cy_s * COLS) + 12'(cx_s);
   assign font_addr = {char_data[CODE_LSB +: 8], line0_q};
   assign sync_in_s = '{v_active: v_active, h_sync: h_sync, v_sync: v_sync};
   assign unused_s  = char_data[14];

   vga_sync_delay #(.WIDTH(3), .DEPTH(PIPE_LAT - 1)) u_sync_delay (
      .clk_i (vga_clk),
      .rst_i (rst),
      .d_i   (sync_in_s),
      .q_o   (sync2_s)
   );

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         line0_q  <= 4'd0;  px0_q  <= 3'd0;  cy0_q <= '0;  cx0_q <= 7'd0;
         line1_q  <= 4'd0;  px1_q  <= 3'd0;  fg1_q <= 3'd0; bg1_q <= 3'd0;
         blink1_q <= 1'b0;  cur1_q <= 1'b0;
      end else begin
         line0_q  <= addr[13:10];
         px0_q    <= addr[2:0];
         cy0_q    <= cy_s;
         cx0_q    <= cx_s;
         line1_q  <= line0_q;
         px1_q    <= px0_q;
         fg1_q    <= char_data[FG_LSB +: 3];
         bg1_q    <= char_data[BG_LSB +: 3];
         blink1_q <= char_data[BLINK_POS];
         cur1_q   <= (5'(cy0_q) == cursor_y) && (cx0_q == cursor_x);
      end
   end

   assign phase_s = frame_q[BLINK_BIT];

   always_comb begin
      fg_sel_s     = fg1_q;
      pix_s        = font_data[3'd7 - px1_q];
      cursor_hit_s = cursor_en && cur1_q && !phase_s &&
                     (4'(line1_q - CURSOR_LINE_LO) <= 4'(CURSOR_LINE_HI - CURSOR_LINE_LO));
      if (blink1_q && phase_s) fg_sel_s = bg1_q;
      else                     fg_sel_s = fg1_q;
      if (cursor_hit_s) pix_s = 1'b1;
      else              pix_s = font_data[3'd7 - px1_q];
      colour_s = pix_s ? fg_sel_s : bg1_q;
      if (sync2_s.v_active) begin
         r_d = expand_bit(colour_s[2]);
         g_d = expand_bit(colour_s[1]);
         b_d = expand_bit(colour_s[0]);
      end else begin
         r_d = 4'h0;
         g_d = 4'h0;
         b_d = 4'h0;
      end
   end

   // Frame count advances on the raw v_sync falling edge.
   always_comb begin
      frame_d = frame_q;
      if (vs_prev_q && !v_sync) frame_d = frame_q + 5'd1;
      else                      frame_d = frame_q;
   end

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         r_q <= 4'h0; g_q <= 4'h0; b_q <= 4'h0;
         hs_q <= 1'b0; vs_q <= 1'b0;
         vs_prev_q <= 1'b0; frame_q <= 5'd0;
      end else begin
         r_q <= r_d; g_q <= g_d; b_q <= b_d;
         hs_q <= sync2_s.h_sync; vs_q <= sync2_s.v_sync;
         vs_prev_q <= v_sync; frame_q <= frame_d;
      end
   end

   assign r  = r_q;
   assign g  = g_q;
   assign b  = b_q;
   assign hs = hs_q;
   assign vs = vs_q;

endmodule

// File: tb/tb_vga_text_render.sv
// Scoreboard bench for vga_text_render with behavioural char RAM and font ROM.
module tb_vga_text_render;

   logic        vga_clk = 1'b0;
   logic        rst = 1'b1;
   logic [18:0] addr = 19'd0;
   logic        v_active = 1'b0, h_sync = 1'b0, v_sync = 1'b0;
   logic [11:0] char_addr, font_addr;
   logic [15:0] char_data;
   logic [7:0]  font_data;
   logic [6:0]  cursor_x = 7'd0;
   logic [4:0]  cursor_y = 5'd0;
   logic        cursor_en = 1'b0;
   logic [3:0]  r, g, b;
   logic        hs, vs;

   logic [15:0] cram [4096];
   logic [7:0]  from [4096];
   logic [4:0]  m_frame = 5'd0;
   logic        m_vs_prev = 1'b0;
   logic [13:0] sb_q [$];
   int          n_checks = 0;
   int          n_fail = 0;

   vga_text_render dut (
      .vga_clk(vga_clk), .rst(rst), .addr(addr), .v_active(v_active),
      .h_sync(h_sync), .v_sync(v_sync), .char_addr(char_addr), .char_data(char_data),
      .font_addr(font_addr), .font_data(font_data), .cursor_x(cursor_x),
      .cursor_y(cursor_y), .cursor_en(cursor_en), .r(r), .g(g), .b(b), .hs(hs), .vs(vs)
   );

   always #20 vga_clk = ~vga_clk;

   always @(posedge vga_clk) begin
      char_data <= cram[char_addr];
      font_data <= from[font_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [13:0] expect_pix(input logic [8:0] row, input logic [9:0] col,
                                              input logic va, input logic hsv, input logic vsv);
      int          cy = row / 16;
      int          cx = col / 8;
      int          line = row % 16;
      int          px = col % 8;
      logic [15:0] w;
      logic [7:0]  gl;
      logic [2:0]  fg, bg, c;
      logic        bitv, phase;
      logic [11:0] rgb;
      w     = cram[cy * 80 + cx];
      gl    = from[{w[7:0], 4'(line)}];
      bitv  = gl[7 - px];
      phase = m_frame[4];
      fg    = w[10:8];
      bg    = w[13:11];
      if (w[15] && phase) fg = bg;
      if (cursor_en && cy == int'(cursor_y) && cx == int'(cursor_x) && line >= 14 && !phase)
         bitv = 1'b1;
      c   = bitv ? fg : bg;
      rgb = va ? {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}} : 12'h000;
      return {rgb, hsv, vsv};
   endfunction

   // One pixel per call: drive on negedge, update model after posedge, compare the entry that is 3 deep.
   task automatic step(input string tag, input logic [8:0] row, input logic [9:0] col,
                       input logic va, input logic hsv, input logic vsv, input logic rs);
      logic [13:0] exp;
      @(negedge vga_clk);
      addr = {row, col}; v_active = va; h_sync = hsv; v_sync = vsv; rst = rs;
      @(posedge vga_clk);
      #1;
      if (rs) begin
         m_frame = 5'd0;
         m_vs_prev = 1'b0;
         foreach (sb_q[i]) sb_q[i] = 14'd0;
         sb_q.push_back(14'd0);
      end else begin
         if (m_vs_prev && !vsv) m_frame = m_frame + 5'd1;
         m_vs_prev = vsv;
         sb_q.push_back(expect_pix(row, col, va, hsv, vsv));
      end
      if (sb_q.size() == 3) begin
         exp = sb_q.pop_front();
         check_eq(tag, {18'd0, r, g, b, hs, vs}, {18'd0, exp});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step("idle", 9'd490, 10'd700, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic frame_tick(input int n);
      for (int i = 0; i < n; i++) begin
         step("vsync_hi", 9'd490, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0);
         step("vsync_hi", 9'd491, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0);
         step("vsync_lo", 9'd492, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         step("vsync_lo", 9'd492, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0);
         step("vsync_lo", 9'd492, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic blink_scan(input string tag);
      for (int l = 0; l < 16; l++)
         step(tag, 9'(32 + l), 10'(80 + $urandom_range(7, 0)), 1'b1, 1'b1, 1'b0, 1'b0);
      idle(3);
   endtask

   task automatic cursor_scan(input string tag);
      for (int l = 0; l < 16; l++) begin
         step(tag, 9'(48 + l), 10'd43, 1'b1, 1'b0, 1'b0, 1'b0);
         step(tag, 9'(48 + l), 10'd51, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      idle(3);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         cram[i] = 16'h0741;
         from[i] = 8'($urandom);
      end
      from[12'h410] = 8'h80;
      cram[170] = 16'h8C42;
      cram[245] = 16'h0220;
      cram[246] = 16'h0220;
      for (int l = 0; l < 16; l++) begin
         from[{8'h42, 4'(l)}] = 8'hFF;
         from[{8'h20, 4'(l)}] = 8'h00;
      end

      for (int i = 0; i < 4; i++)
         step("reset", 9'($urandom_range(479, 0)), 10'($urandom_range(639, 0)),
              1'b1, 1'($urandom), 1'($urandom), 1'b1);

      for (int i = 0; i < 60; i++)
         step("sync_blank", 9'($urandom_range(511, 0)), 10'($urandom_range(1023, 0)),
              1'b0, 1'($urandom), 1'($urandom), 1'b0);
      idle(3);

      for (int i = 0; i < 120; i++)
         step("pix_rand", 9'($urandom_range(479, 0)), 10'($urandom_range(639, 0)),
              1'($urandom_range(3, 0) != 0), 1'($urandom), 1'b0, 1'b0);

      for (int c = 0; c < 12; c++)
         step("rst_mid", 9'd100, 10'(200 + c), 1'b1, 1'b1, 1'b0, c == 4);
      idle(3);

      step("pix_00", 9'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("char_addr_00", {20'd0, char_addr}, 32'd0);
      check_eq("font_addr_00", {20'd0, font_addr}, 32'h410);
      step("pix_01", 9'd0, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      step("pix_last", 9'd479, 10'd639, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("char_addr_last", {20'd0, char_addr}, 32'd2399);
      check_eq("font_line_last", {28'd0, font_addr[3:0]}, 32'd15);
      check_eq("font_addr_last", {20'd0, font_addr}, 32'h41F);
      idle(3);

      cursor_x = 7'd5; cursor_y = 5'd3; cursor_en = 1'b1;
      cursor_scan("cursor_ph0");
      cursor_en = 1'b0;
      cursor_scan("cursor_off");
      blink_scan("blink_ph0");

      frame_tick(16);
      blink_scan("blink_ph1");
      cursor_en = 1'b1;
      cursor_scan("cursor_ph1");
      cursor_en = 1'b0;

      frame_tick(16);
      blink_scan("blink_wrap");

      frame_tick(16);
      for (int c = 0; c < 10; c++)
         step("rst_frame", 9'd33, 10'(80 + c), 1'b1, 1'b0, 1'b0, c == 3);
      blink_scan("blink_after_rst");

      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
